grid_access_sequencer: RTL and testbench
========================================

// Module: grid_access_sequencer
// PURPOSE
//  Owns the single-port 64x4 candy-grid RAM. It executes game-FSM commands (read, black, random, swap) as fixed access sequences.
//  It shares idle RAM cycles with the VGA cell reader, with a starvation guard, and generates random candy colours with an LFSR.
//  It sits between the game state machine, the display scanner and the grid memory.
// PARAMETERS
//  NUM_COLORS  6        legal candy colours 1..NUM_COLORS (0 = black/empty); range 4..8
//  STARVE_MAX  8        consecutive denied VGA-request cycles before VGA is forced the port (1..15)
//  LFSR_SEED   16'hACE1 LFSR reset value; must be nonzero
// PORTS
//  Clk       in   1  clock
//  Reset     in   1  synchronous, active-high reset
//  CmdValid  in   1  command offered
//  CmdReady  out  1  command accepted when CmdValid&&CmdReady at a rising edge
//  CmdOp     in   2  00 READ A, 01 BLACK A, 10 RANDOM A, 11 SWAP A<->B
//  CmdAX/CmdAY in 3+3  cell A column/row
//  CmdBX/CmdBY in 3+3  cell B column/row (SWAP only)
//  RspData   out  4  READ result; holds until the next READ completes
//  Done      out  1  one-cycle completion pulse
//  VgaReq    in   1  display wants cell (VgaX,VgaY)
//  VgaX/VgaY in   3+3  display cell
//  VgaGrant  out  1  RAM serves VGA this cycle (combinational)
//  VgaData   out  4  cell colour; valid when VgaValid=1
//  VgaValid  out  1  VgaGrant delayed one cycle
//  MemAddr   out  6  {row,col} = {Y,X}
//  MemWe     out  1  write strobe
//  MemWData  out  4  write data
//  MemRData  in   4  read data, valid one cycle after address (sync RAM)
// BEHAVIOUR
//  Reset: state IDLE. CmdReady=1 unless the guard trips. Done=0, VgaValid=0, RspData=0, VgaData=0, MemWe=0. StarveCnt=0, LFSR=LFSR_SEED.
//  Reset mid-sequence aborts the operation: no further RAM writes occur, and a half-done swap is left as-is.
//  States: IDLE, RD_CAP, SW_RDB, SW_WRA, SW_WRB. The RAM port mux is combinational on state and inputs.
//  IDLE, forced=(StarveCnt>=STARVE_MAX)&&VgaReq: CmdReady=0, VgaGrant=1, MemAddr=VGA cell.
//  IDLE, not forced: CmdReady=1. On accept, the command's first access drives the RAM in the same cycle (t). Else if VgaReq, VGA gets the port.
//  READ: t addr=A -> RD_CAP. t+1 RspData<=MemRData -> IDLE. Done=1 at t+2.
//  BLACK: t addr=A, MemWe=1, MemWData=0 -> IDLE. Done=1 at t+1.
//  RANDOM: t addr=A, MemWe=1, MemWData=colour -> IDLE. Done=1 at t+1.
//  SWAP timing:
//    t addr=A read -> SW_RDB.
//    t+1 addr=B read, latchA<=MemRData -> SW_WRA.
//    t+2 addr=A, we, wdata=MemRData (B's value) -> SW_WRB.
//    t+3 addr=B, we, wdata=latchA -> IDLE. Done=1 at t+4.
//  SWAP with A==B is executed normally and leaves the cell unchanged.
//  Non-IDLE states: CmdReady=0, VgaGrant=0. Back-to-back commands are accepted in the Done cycle.
//  VgaValid<=VgaGrant. VgaData<=MemRData in the cycle after a grant and holds otherwise.
//  StarveCnt: +1 (saturating at 15) each cycle VgaReq&&!VgaGrant. Cleared on VgaGrant or !VgaReq.
//  LFSR: 16-bit Galois, mask 16'hB400, shifts every cycle.
//    c=lfsr[2:0]; colour = (c>=NUM_COLORS ? c-NUM_COLORS : c) + 1, always in 1..NUM_COLORS.
//  MemWe is 0 in every cycle not listed above. MemAddr is don't-care when MemWe=0 and there is no read.
// TESTING
//  Preload cell(2,3)=5, cell(3,3)=2; SWAP A=(2,3) B=(3,3) -> write sequence {addr 26 data 2, addr 27 data 5}; Done exactly 4 cycles after accept; CmdReady=0 for cycles t+1..t+3.
//  BLACK A=(7,7) -> MemAddr=63, MemWe=1, MemWData=0 in the accept cycle; Done next cycle. READ A=(7,7) -> RspData=0 and Done 2 cycles after accept.
//  1000 RANDOM commands, NUM_COLORS=6 -> every MemWData in 1..6, never 0 or 7; all six values appear.
//  VgaReq held high while CmdValid is held high with back-to-back BLACK -> VgaGrant within STARVE_MAX+4 cycles; CmdReady=0 during that forced IDLE cycle; VgaValid one cycle later with correct data.
//  Reset asserted at SW_WRA of a swap -> no MemWe after reset; state IDLE; Done=0; cell A and cell B hold pre-swap values.
//  VgaReq in an IDLE cycle with CmdValid=0 -> VgaGrant=1 same cycle, MemAddr={VgaY,VgaX}, VgaData correct next cycle.

Source files
------------

// File: rtl/grid_access_sequencer_if.sv
// Bundles the command, display-reader and grid-RAM signals of the grid access sequencer.
// slave is the sequencer's view; master is the surrounding game/display/RAM view.
interface grid_access_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_ax, cmd_ay, cmd_bx, cmd_by;
    logic [3:0] rsp_data;
    logic       done;
    logic       vga_req;
    logic [2:0] vga_x, vga_y;
    logic       vga_grant;
    logic [3:0] vga_data;
    logic       vga_valid;
    logic [5:0] mem_addr;
    logic       mem_we;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata;

    modport slave (
        input  cmd_valid, cmd_op, cmd_ax, cmd_ay, cmd_bx, cmd_by, vga_req, vga_x, vga_y, mem_rdata,
        output cmd_ready, rsp_data, done, vga_grant, vga_data, vga_valid, mem_addr, mem_we, mem_wdata
    );
    modport master (
        output cmd_valid, cmd_op, cmd_ax, cmd_ay, cmd_bx, cmd_by, vga_req, vga_x, vga_y, mem_rdata,
        input  cmd_ready, rsp_data, done, vga_grant, vga_data, vga_valid, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/grid_access_sequencer.sv
// Owns the single-port 64x4 candy-grid RAM: runs game commands as fixed access sequences,
// lends idle cycles to the display reader (with a starvation guard) and makes random colours.
module grid_access_sequencer #(
    parameter int          NUM_COLORS = 6,
    parameter int          STARVE_MAX = 8,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic                    clk_i,
    input logic                    rst_i,
    grid_access_sequencer_if.slave bus_io
);
    typedef enum logic [2:0] {IDLE, RD_CAP, SW_RDB, SW_WRA, SW_WRB} state_e;

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_BLACK  = 2'd1;
    localparam logic [1:0] OP_RANDOM = 2'd2;
    localparam logic [3:0] NC        = 4'(NUM_COLORS);
    localparam logic [3:0] SMAX      = 4'(STARVE_MAX);

    state_e      state_q, state_d;
    logic        done_q, done_d;
    logic [3:0]  rsp_q, vga_hold_q, latch_a_q;
    logic [3:0]  starve_q, starve_d;
    logic        vga_valid_q;
    logic [15:0] lfsr_q, lfsr_d;
    logic [5:0]  a_addr_q, b_addr_q;

    logic [5:0]  cmd_a, cmd_b, vga_addr, addr;
    logic [3:0]  colour, c4, wdata;
    logic        forced, accept, grant, we, ready;

    assign cmd_a    = {bus_io.cmd_ay, bus_io.cmd_ax};
    assign cmd_b    = {bus_io.cmd_by, bus_io.cmd_bx};
    assign vga_addr = {bus_io.vga_y, bus_io.vga_x};
    assign forced   = (starve_q >= SMAX) && bus_io.vga_req;

    assign c4     = {1'b0, lfsr_q[2:0]};
    assign colour = ((c4 >= NC) ? (c4 - NC) : c4) + 4'd1;
    assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        ready   = 1'b0;
        grant   = 1'b0;
        accept  = 1'b0;
        addr    = a_addr_q;
        we      = 1'b0;
        wdata   = 4'd0;
        unique case (state_q)
            IDLE: begin
                ready = !forced;
                if (forced) begin
                    grant = 1'b1;
                    addr  = vga_addr;
                end else if (bus_io.cmd_valid) begin
                    // First access of the command goes out in the accept cycle itself.
                    accept = 1'b1;
                    addr   = cmd_a;
                    case (bus_io.cmd_op)
                        OP_READ:   state_d = RD_CAP;
                        OP_BLACK:  begin we = 1'b1; done_d = 1'b1; end
                        OP_RANDOM: begin we = 1'b1; wdata = colour; done_d = 1'b1; end
                        default:   state_d = SW_RDB;
                    endcase
                end else if (bus_io.vga_req) begin
                    grant = 1'b1;
                    addr  = vga_addr;
                end
            end
            RD_CAP: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            SW_RDB: begin
                addr    = b_addr_q;
                state_d = SW_WRA;
            end
            SW_WRA: begin
                addr    = a_addr_q;
                we      = 1'b1;
                wdata   = bus_io.mem_rdata;
                state_d = SW_WRB;
            end
            SW_WRB: begin
                addr    = b_addr_q;
                we      = 1'b1;
                wdata   = latch_a_q;
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        starve_d = 4'd0;
        if (bus_io.vga_req && !grant)
            starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
    end

    // A reset landing mid-swap must not let the pending write through.
    assign bus_io.mem_we    = we && !rst_i;
    assign bus_io.mem_addr  = addr;
    assign bus_io.mem_wdata = wdata;
    assign bus_io.cmd_ready = ready;
    assign bus_io.vga_grant = grant;
    assign bus_io.done      = done_q;
    assign bus_io.rsp_data  = rsp_q;
    assign bus_io.vga_valid = vga_valid_q;
    assign bus_io.vga_data  = vga_valid_q ? bus_io.mem_rdata : vga_hold_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            rsp_q       <= 4'd0;
            vga_hold_q  <= 4'd0;
            latch_a_q   <= 4'd0;
            starve_q    <= 4'd0;
            vga_valid_q <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            a_addr_q    <= 6'd0;
            b_addr_q    <= 6'd0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            starve_q    <= starve_d;
            vga_valid_q <= grant;
            lfsr_q      <= lfsr_d;
            if (vga_valid_q)       vga_hold_q <= bus_io.mem_rdata;
            if (state_q == RD_CAP) rsp_q      <= bus_io.mem_rdata;
            if (state_q == SW_RDB) latch_a_q  <= bus_io.mem_rdata;
            if (accept) begin
                a_addr_q <= cmd_a;
                b_addr_q <= cmd_b;
            end
        end
    end
endmodule

// File: tb/tb_grid_access_sequencer.sv
// Bench for grid_access_sequencer: directed command table, corner sequences and a
// randomized run against a transaction-level grid model.
module tb_grid_access_sequencer;
    localparam int          NCOL  = 6;
    localparam int          SMAX  = 8;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    grid_access_sequencer_if bus();
    grid_access_sequencer #(.NUM_COLORS(NCOL), .STARVE_MAX(SMAX), .LFSR_SEED(SEED))
        dut (.clk_i(clk), .rst_i(rst), .bus_io(bus));

    // Synchronous grid RAM with a bench-only preload port.
    logic [3:0] ram [64];
    logic       pre_we = 1'b0;
    logic [5:0] pre_addr = 6'd0;
    logic [3:0] pre_data = 4'd0;
    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    typedef struct { logic [5:0] a; logic [3:0] d; } wr_t;
    wr_t wlog[$];
    always @(posedge clk) if (bus.mem_we) wlog.push_back('{bus.mem_addr, bus.mem_wdata});

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] x;
        x = s >> 1;
        if (s[0]) x = x ^ 16'hB400;
        return x;
    endfunction
    function automatic logic [3:0] colour_of(input logic [15:0] s);
        return 4'((int'(s[2:0]) % NCOL) + 1);
    endfunction
    logic [15:0] lfsr_m;
    always @(posedge clk) lfsr_m <= rst ? SEED : lfsr_step(lfsr_m);

    int total = 0;
    int bad = 0;
    logic [3:0] ref_grid [64];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] init_val(input int i);
        if (i == 26) return 4'd5;
        if (i == 27) return 4'd2;
        if (i == 9)  return 4'd3;
        return 4'((i * 3 + 1) % 7);
    endfunction

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0;
        bus.cmd_ax = 3'd0; bus.cmd_ay = 3'd0; bus.cmd_bx = 3'd0; bus.cmd_by = 3'd0;
        bus.vga_req = 1'b0; bus.vga_x = 3'd0; bus.vga_y = 3'd0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic preload();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_addr = 6'(i); pre_data = init_val(i);
            ref_grid[i] = init_val(i);
        end
        @(negedge clk); pre_we = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [2:0] ax, input logic [2:0] ay,
                           input logic [2:0] bx, input logic [2:0] by,
                           output int lat, output logic [3:0] rsp, output logic awe,
                           output logic [5:0] aaddr, output logic [3:0] awd, output int bready);
        int n;
        n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op;
        bus.cmd_ax = ax; bus.cmd_ay = ay; bus.cmd_bx = bx; bus.cmd_by = by;
        #1;
        while (!bus.cmd_ready && n < 40) begin @(negedge clk); #1; n++; end
        chk("accept_in_time", int'(n < 40), 1);
        awe = bus.mem_we; aaddr = bus.mem_addr; awd = bus.mem_wdata;
        wlog.delete();
        @(negedge clk); bus.cmd_valid = 1'b0;
        lat = 1; bready = 0;
        #1;
        while (!bus.done && lat < 20) begin
            if (bus.cmd_ready) bready++;
            @(negedge clk); #1; lat++;
        end
        rsp = bus.rsp_data;
    endtask

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [2:0] ax, ay, bx, by;
        int         lat;
        logic       we;
        logic [5:0] addr;
        logic [3:0] wdata;
        logic       chk_rsp;
        logic [3:0] rsp;
    } vec_t;

    initial begin
        vec_t vecs [7];
        int lat, bready, n;
        logic [3:0] rsp, awd;
        logic awe, got;
        logic [5:0] aaddr;
        logic [7:0] seen;

        vecs[0] = '{"swap_23_33",  2'd3, 3'd2, 3'd3, 3'd3, 3'd3, 4, 1'b0, 6'd26, 4'd0, 1'b0, 4'd0};
        vecs[1] = '{"read_23",     2'd0, 3'd2, 3'd3, 3'd0, 3'd0, 2, 1'b0, 6'd26, 4'd0, 1'b1, 4'd2};
        vecs[2] = '{"read_33",     2'd0, 3'd3, 3'd3, 3'd0, 3'd0, 2, 1'b0, 6'd27, 4'd0, 1'b1, 4'd5};
        vecs[3] = '{"black_77",    2'd1, 3'd7, 3'd7, 3'd0, 3'd0, 1, 1'b1, 6'd63, 4'd0, 1'b0, 4'd0};
        vecs[4] = '{"read_77",     2'd0, 3'd7, 3'd7, 3'd0, 3'd0, 2, 1'b0, 6'd63, 4'd0, 1'b1, 4'd0};
        vecs[5] = '{"swap_same",   2'd3, 3'd1, 3'd1, 3'd1, 3'd1, 4, 1'b0, 6'd9,  4'd0, 1'b0, 4'd0};
        vecs[6] = '{"read_11",     2'd0, 3'd1, 3'd1, 3'd0, 3'd0, 2, 1'b0, 6'd9,  4'd0, 1'b1, 4'd3};

        idle_inputs();
        do_reset();
        #1;
        chk("rst_done",      int'(bus.done), 0);
        chk("rst_vga_valid", int'(bus.vga_valid), 0);
        chk("rst_rsp",       int'(bus.rsp_data), 0);
        chk("rst_vga_data",  int'(bus.vga_data), 0);
        chk("rst_mem_we",    int'(bus.mem_we), 0);
        chk("rst_ready",     int'(bus.cmd_ready), 1);

        preload();
        for (int v = 0; v < 7; v++) begin
            run_cmd(vecs[v].op, vecs[v].ax, vecs[v].ay, vecs[v].bx, vecs[v].by, lat, rsp, awe, aaddr, awd, bready);
            chk({vecs[v].name, "_lat"},   lat, vecs[v].lat);
            chk({vecs[v].name, "_we"},    int'(awe), int'(vecs[v].we));
            chk({vecs[v].name, "_addr"},  int'(aaddr), int'(vecs[v].addr));
            chk({vecs[v].name, "_busy"},  bready, 0);
            if (vecs[v].we) chk({vecs[v].name, "_wdata"}, int'(awd), int'(vecs[v].wdata));
            if (vecs[v].chk_rsp) chk({vecs[v].name, "_rsp"}, int'(rsp), int'(vecs[v].rsp));
            if (v == 0) begin
                chk("swap_nwrites", wlog.size(), 2);
                if (wlog.size() == 2) begin
                    chk("swap_w0_addr", int'(wlog[0].a), 26); chk("swap_w0_data", int'(wlog[0].d), 2);
                    chk("swap_w1_addr", int'(wlog[1].a), 27); chk("swap_w1_data", int'(wlog[1].d), 5);
                end
            end
        end

        // Reset landing in the SW_WRA cycle of a swap between cells 8 and 21.
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd3;
        bus.cmd_ax = 3'd0; bus.cmd_ay = 3'd1; bus.cmd_bx = 3'd5; bus.cmd_by = 3'd2;
        #1; chk("rswap_ready", int'(bus.cmd_ready), 1);
        @(negedge clk); bus.cmd_valid = 1'b0;
        @(negedge clk); rst = 1'b1; wlog.delete();
        #1; chk("rswap_we_gated", int'(bus.mem_we), 0);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rswap_done", int'(bus.done), 0);
        chk("rswap_ready_after", int'(bus.cmd_ready), 1);
        repeat (3) @(negedge clk);
        chk("rswap_no_writes", wlog.size(), 0);
        run_cmd(2'd0, 3'd0, 3'd1, 3'd0, 3'd0, lat, rsp, awe, aaddr, awd, bready);
        chk("rswap_cellA", int'(rsp), int'(ref_grid[8]));
        chk("rswap_readlat", lat, 2);
        run_cmd(2'd0, 3'd5, 3'd2, 3'd0, 3'd0, lat, rsp, awe, aaddr, awd, bready);
        chk("rswap_cellB", int'(rsp), int'(ref_grid[21]));

        // Idle display read.
        @(negedge clk); bus.vga_req = 1'b1; bus.vga_x = 3'd6; bus.vga_y = 3'd2;
        #1;
        chk("vga_idle_grant", int'(bus.vga_grant), 1);
        chk("vga_idle_addr",  int'(bus.mem_addr), 22);
        @(negedge clk); bus.vga_req = 1'b0;
        #1;
        chk("vga_idle_valid", int'(bus.vga_valid), 1);
        chk("vga_idle_data",  int'(bus.vga_data), int'(ref_grid[22]));
        @(negedge clk); #1;
        chk("vga_idle_valid_drop", int'(bus.vga_valid), 0);
        chk("vga_idle_data_hold",  int'(bus.vga_data), int'(ref_grid[22]));

        // Starvation guard under back-to-back BLACK commands.
        do_reset();
        @(negedge clk);
        bus.vga_req = 1'b1; bus.vga_x = 3'd6; bus.vga_y = 3'd4;
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd1; bus.cmd_ax = 3'd0; bus.cmd_ay = 3'd0;
        n = 0; got = 1'b0;
        while (!got && n <= SMAX + 4) begin
            #1;
            if (bus.vga_grant) begin
                got = 1'b1;
                chk("starve_ready", int'(bus.cmd_ready), 0);
                chk("starve_addr",  int'(bus.mem_addr), 38);
            end
            @(negedge clk);
            if (!got) n++;
        end
        bus.vga_req = 1'b0; bus.cmd_valid = 1'b0;
        ref_grid[0] = 4'd0;
        chk("starve_granted", int'(got), 1);
        chk("starve_cycles",  n, SMAX);
        #1;
        chk("starve_valid", int'(bus.vga_valid), 1);
        chk("starve_data",  int'(bus.vga_data), int'(ref_grid[38]));

        // 1000 back-to-back RANDOM commands.
        do_reset();
        seen = 8'd0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2;
        for (int k = 0; k < 1000; k++) begin
            bus.cmd_ax = 3'($urandom_range(0, 7)); bus.cmd_ay = 3'($urandom_range(0, 7));
            #1;
            chk("rnd_we", int'(bus.mem_we), 1);
            chk("rnd_colour", int'(bus.mem_wdata), int'(colour_of(lfsr_m)));
            chk("rnd_range", int'(bus.mem_wdata >= 4'd1 && bus.mem_wdata <= 4'd6), 1);
            seen[bus.mem_wdata[2:0]] = 1'b1;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        chk("rnd_all_seen", int'(seen), 8'b0111_1110);

        // Randomized mix against the transaction-level grid model.
        preload();
        do_reset();
        begin
            int busy_until, done_at, starve, lat_m;
            logic vv, egrant, eready, idle, frc, rsp_chk, acc_prev;
            logic [3:0] vexp, rsp_exp, tmp;
            logic [5:0] a, b, va;
            busy_until = 0; done_at = -1; starve = 0;
            vv = 1'b0; rsp_chk = 1'b0; acc_prev = 1'b0; vexp = 4'd0; rsp_exp = 4'd0;
            for (int c = 0; c < 600; c++) begin
                @(negedge clk);
                if (acc_prev) bus.cmd_valid = 1'b0;
                if (!bus.cmd_valid && $urandom_range(0, 1) == 1) begin
                    bus.cmd_valid = 1'b1; bus.cmd_op = 2'($urandom_range(0, 3));
                    bus.cmd_ax = 3'($urandom_range(0, 7)); bus.cmd_ay = 3'($urandom_range(0, 7));
                    bus.cmd_bx = 3'($urandom_range(0, 7)); bus.cmd_by = 3'($urandom_range(0, 7));
                end
                bus.vga_req = ($urandom_range(0, 3) != 0);
                bus.vga_x = 3'($urandom_range(0, 7)); bus.vga_y = 3'($urandom_range(0, 7));
                #1;
                idle   = (c >= busy_until);
                frc    = idle && starve >= SMAX && bus.vga_req;
                eready = idle && !frc;
                egrant = idle && bus.vga_req && (frc || !bus.cmd_valid);
                chk("m_ready", int'(bus.cmd_ready), int'(eready));
                chk("m_grant", int'(bus.vga_grant), int'(egrant));
                chk("m_done",  int'(bus.done), int'(c == done_at));
                chk("m_vvalid", int'(bus.vga_valid), int'(vv));
                if (vv) chk("m_vdata", int'(bus.vga_data), int'(vexp));
                if (c == done_at && rsp_chk) chk("m_rsp", int'(bus.rsp_data), int'(rsp_exp));
                va = {bus.vga_y, bus.vga_x};
                vv = egrant;
                if (egrant) begin
                    chk("m_vaddr", int'(bus.mem_addr), int'(va));
                    vexp = ref_grid[va];
                end
                acc_prev = bus.cmd_valid && eready;
                if (acc_prev) begin
                    a = {bus.cmd_ay, bus.cmd_ax}; b = {bus.cmd_by, bus.cmd_bx};
                    chk("m_acc_addr", int'(bus.mem_addr), int'(a));
                    rsp_chk = 1'b0;
                    case (bus.cmd_op)
                        2'd0: begin lat_m = 2; rsp_chk = 1'b1; rsp_exp = ref_grid[a];
                                    chk("m_read_we", int'(bus.mem_we), 0); end
                        2'd1: begin lat_m = 1; chk("m_black_we", int'(bus.mem_we), 1);
                                    chk("m_black_wd", int'(bus.mem_wdata), 0); ref_grid[a] = 4'd0; end
                        2'd2: begin lat_m = 1; chk("m_rnd_we", int'(bus.mem_we), 1);
                                    chk("m_rnd_wd", int'(bus.mem_wdata), int'(colour_of(lfsr_m)));
                                    ref_grid[a] = colour_of(lfsr_m); end
                        default: begin lat_m = 4; chk("m_swap_we", int'(bus.mem_we), 0);
                                    tmp = ref_grid[a]; ref_grid[a] = ref_grid[b]; ref_grid[b] = tmp; end
                    endcase
                    busy_until = c + lat_m; done_at = c + lat_m;
                end
                starve = (bus.vga_req && !egrant) ? ((starve == 15) ? 15 : starve + 1) : 0;
            end
        end
        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end
endmodule
